// File: rtl/hs32_mem_pkg.sv
// Shared types and constants for the hs32 memory arbiter.
package hs32_mem_pkg;

    localparam int unsigned WORD = 32;
    localparam int unsigned CHW  = 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    typedef logic [CHW-1:0] chan_t;

    typedef struct packed {
        logic [WORD-1:0] addr;
        logic            we;
        logic [WORD-1:0] dout;
    } mem_cmd_t;

    // Word alignment clears the byte-lane bits when enabled.
    function automatic logic [WORD-1:0] align_addr(input logic [WORD-1:0] a, input logic en);
        return en ? {a[WORD-1:2], 2'b00} : a;
    endfunction

endpackage

// File: rtl/hs32_rr2.sv
// Two-way round-robin picker: with both requesting, the channel that was not served last wins.
module hs32_rr2
    import hs32_mem_pkg::*;
(
    input  logic [1:0] req,
    input  chan_t      last,
    output chan_t      gnt,
    output logic       valid
);

    // Pick a channel from the current requests and the last grant.
    always_comb begin
        valid = |req;
        gnt   = '0;
        if (req == 2'b11) begin
            gnt = ~last;
        end else if (req[1]) begin
            gnt = 1'b1;
        end
    end

endmodule

// File: rtl/hs32_mem_arb.sv
// hs32 memory arbiter: two requesters share one downstream memory port, one
// transaction in flight, with a timeout that returns an error response.
module hs32_mem_arb
    import hs32_mem_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned TW      = 8,
    parameter logic        ALIGN   = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [WORD-1:0] addr0,
    input  logic            rw0,
    input  logic [WORD-1:0] dtw0,
    input  logic            reqm0,
    output logic            ackm0,
    input  logic [WORD-1:0] addr1,
    input  logic            rw1,
    input  logic [WORD-1:0] dtw1,
    input  logic            reqm1,
    output logic            ackm1,
    output logic [WORD-1:0] dtr,
    output logic            err,
    output logic [WORD-1:0] mem_addr,
    output logic            mem_we,
    output logic [WORD-1:0] mem_dout,
    output logic            mem_req,
    input  logic [WORD-1:0] mem_din,
    input  logic            mem_ack
);

    localparam logic [TW-1:0] CNT_LAST = TW'(TIMEOUT - 1);

    state_e          state_q;
    chan_t           gnt_q;
    chan_t           last_q;
    logic [TW-1:0]   cnt_q;
    logic            ackm0_q;
    logic            ackm1_q;
    logic            err_q;
    logic [WORD-1:0] dtr_q;
    logic            mem_req_q;
    logic            mem_we_q;
    logic [WORD-1:0] mem_addr_q;
    logic [WORD-1:0] mem_dout_q;

    chan_t           pick_gnt;
    logic            pick_valid;
    mem_cmd_t        cmd_d;

    hs32_rr2 u_rr2 (
        .req   ({reqm1, reqm0}),
        .last  (last_q),
        .gnt   (pick_gnt),
        .valid (pick_valid)
    );

    // Select the command fields of the picked channel for latching.
    always_comb begin
        cmd_d = '0;
        if (pick_gnt == 1'b1) begin
            cmd_d.addr = align_addr(addr1, ALIGN);
            cmd_d.we   = rw1;
            cmd_d.dout = dtw1;
        end else begin
            cmd_d.addr = align_addr(addr0, ALIGN);
            cmd_d.we   = rw0;
            cmd_d.dout = dtw0;
        end
    end

    // Arbitration FSM with registered outputs and timeout counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            gnt_q      <= '0;
            last_q     <= 1'b1;
            cnt_q      <= '0;
            ackm0_q    <= 1'b0;
            ackm1_q    <= 1'b0;
            err_q      <= 1'b0;
            dtr_q      <= '0;
            mem_req_q  <= 1'b0;
            mem_we_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_dout_q <= '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (pick_valid) begin
                        gnt_q      <= pick_gnt;
                        mem_addr_q <= cmd_d.addr;
                        mem_we_q   <= cmd_d.we;
                        mem_dout_q <= cmd_d.dout;
                        mem_req_q  <= 1'b1;
                        cnt_q      <= '0;
                        state_q    <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    // Completion wins over a timeout landing in the same cycle.
                    if (mem_ack) begin
                        dtr_q     <= mem_we_q ? '0 : mem_din;
                        err_q     <= 1'b0;
                        mem_req_q <= 1'b0;
                        ackm0_q   <= (gnt_q == 1'b0);
                        ackm1_q   <= (gnt_q == 1'b1);
                        state_q   <= ST_RESP;
                    end else if (cnt_q == CNT_LAST) begin
                        dtr_q     <= '0;
                        err_q     <= 1'b1;
                        mem_req_q <= 1'b0;
                        ackm0_q   <= (gnt_q == 1'b0);
                        ackm1_q   <= (gnt_q == 1'b1);
                        state_q   <= ST_RESP;
                    end else begin
                        cnt_q <= cnt_q + TW'(1);
                    end
                end
                ST_RESP: begin
                    ackm0_q <= 1'b0;
                    ackm1_q <= 1'b0;
                    err_q   <= 1'b0;
                    last_q  <= gnt_q;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign ackm0    = ackm0_q;
    assign ackm1    = ackm1_q;
    assign err      = err_q;
    assign dtr      = dtr_q;
    assign mem_req  = mem_req_q;
    assign mem_we   = mem_we_q;
    assign mem_addr = mem_addr_q;
    assign mem_dout = mem_dout_q;

endmodule
